// File: rtl/acq_pio_pkg.sv
// Shared constants for the acquisition status PIO.
// Register word addresses and edge capture encodings.
package acq_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/acq_status_pio_if.sv
// Avalon-MM slave bus bundle for the acquisition status PIO.
// Host side drives the master modport, the PIO takes the slave modport.
interface acq_status_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/acq_pio_sync.sv
// Two-flop synchronizer for asynchronous front-end status lines.
module acq_pio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/acq_status_pio.sv
// W-bit Avalon-MM input PIO with per-bit edge capture and maskable irq.
// Define ACQ_STATUS_PIO_SYNC_EN to put a two-flop synchronizer before the sampler.
module acq_status_pio
    import acq_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISING,
    parameter int IRQ_EN    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    acq_status_pio_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] smp_in;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             primed_q;
    logic             wr_en;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wdata;

`ifdef ACQ_STATUS_PIO_SYNC_EN
    acq_pio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (in_port),
        .q_o   (smp_in)
    );
`else
    assign smp_in = in_port;
`endif

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        edge_det = '0;
        if (primed_q) begin
            case (EDGE_TYPE)
                EDGE_FALLING: edge_det = ~s_q & p_q;
                EDGE_ANY:     edge_det = s_q ^ p_q;
                default:      edge_det = s_q & ~p_q;
            endcase
        end
        clr = '0;
        if (wr_en && bus.address == ADDR_EDGECAP)
            clr = bus.writedata[WIDTH-1:0];
        // A fresh edge beats a same-cycle clear.
        cap_d  = (cap_q & ~clr) | edge_det;
        mask_d = mask_q;
        if (IRQ_EN != 0 && wr_en && bus.address == ADDR_IRQMASK)
            mask_d = bus.writedata[WIDTH-1:0];
        rdata_d = '0;
        unique case (bus.address)
            ADDR_DATA:    rdata_d = 32'(s_q);
            ADDR_RSVD:    rdata_d = '0;
            ADDR_IRQMASK: rdata_d = 32'(mask_q);
            ADDR_EDGECAP: rdata_d = 32'(cap_q);
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q      <= '0;
            p_q      <= '0;
            primed_q <= 1'b0;
            mask_q   <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
        end else begin
            s_q      <= smp_in;
            // First sample seeds p too, so reset values never look like edges.
            p_q      <= primed_q ? s_q : smp_in;
            primed_q <= 1'b1;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq = (IRQ_EN != 0) ? |(cap_q & mask_q) : 1'b0;

endmodule

// File: tb/tb_acq_status_pio.sv
// Scoreboard bench for acq_status_pio: rising, falling, any-edge and 1-bit DUTs.
module tb_acq_status_pio;
    import acq_pio_pkg::*;

`ifdef ACQ_STATUS_PIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  addr;
    logic [3:0]  cs;
    logic        wn;
    logic [31:0] wdata;
    logic [7:0]  in_r, in_f, in_a;
    logic        in_1;
    logic [3:0]  irq_v;
    logic [31:0] rdv [4];

    logic [31:0] exp_q [$];
    int          tot = 0;
    int          pass = 0;

    always #5 clk = ~clk;

    acq_status_pio_if bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_bus
        assign bus[g].address    = addr;
        assign bus[g].chipselect = cs[g];
        assign bus[g].write_n    = wn;
        assign bus[g].writedata  = wdata;
        assign rdv[g]            = bus[g].readdata;
    end

    acq_status_pio #(.WIDTH(8), .EDGE_TYPE(EDGE_RISING), .IRQ_EN(1)) u_rise (
        .clk(clk), .reset_n(rst_n), .bus(bus[0]), .in_port(in_r), .irq(irq_v[0]));
    acq_status_pio #(.WIDTH(8), .EDGE_TYPE(EDGE_FALLING), .IRQ_EN(1)) u_fall (
        .clk(clk), .reset_n(rst_n), .bus(bus[1]), .in_port(in_f), .irq(irq_v[1]));
    acq_status_pio #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY), .IRQ_EN(1)) u_any (
        .clk(clk), .reset_n(rst_n), .bus(bus[2]), .in_port(in_a), .irq(irq_v[2]));
    acq_status_pio #(.WIDTH(1), .EDGE_TYPE(EDGE_RISING), .IRQ_EN(1)) u_w1 (
        .clk(clk), .reset_n(rst_n), .bus(bus[3]), .in_port(in_1), .irq(irq_v[3]));

    typedef struct {
        int          k;
        logic [1:0]  a;
        logic [31:0] e;
        string       n;
    } rq_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int k, input logic [1:0] a, output logic [31:0] v);
        addr = a;
        @(posedge clk);
        #1;
        v = rdv[k];
    endtask

    task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
        cs    = 4'(1 << k);
        wn    = 1'b0;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        cs = '0;
        wn = 1'b1;
    endtask

    task automatic test_reset;
        rq_t rl[$];
        logic [31:0] obs, e;
        repeat (3) @(posedge clk);
        #1;
        tot++;
        if (irq_v !== 4'h0) $display("FAIL rst_irq got %h want 0", irq_v);
        else pass++;
        tot++;
        if (rdv[0] !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdv[0]);
        else pass++;
        rst_n = 1'b1;
        tick(3);
        tot++;
        if (irq_v !== 4'h0) $display("FAIL rst_irq_post got %h want 0", irq_v);
        else pass++;
        rl.push_back('{0, ADDR_DATA,    32'h0000_00FF, "rst_data_r"});
        rl.push_back('{0, ADDR_EDGECAP, 32'h0,         "rst_cap_r"});
        rl.push_back('{1, ADDR_EDGECAP, 32'h0,         "rst_cap_f"});
        rl.push_back('{2, ADDR_EDGECAP, 32'h0,         "rst_cap_a"});
        rl.push_back('{0, ADDR_IRQMASK, 32'h0,         "rst_mask_r"});
        for (int i = 0; i < rl.size(); i++) begin
            exp_q.push_back(rl[i].e);
            rd(rl[i].k, rl[i].a, obs);
            e = exp_q.pop_front();
            tot++;
            if (obs !== e) $display("FAIL %s got %h want %h", rl[i].n, obs, e);
            else pass++;
        end
    endtask

    task automatic test_rising;
        logic [31:0] obs, e;
        in_r = 8'h00;
        tick(LAT + 2);
        wr(0, ADDR_IRQMASK, 32'h1);
        in_r = 8'h01;
        tick(LAT);
        tot++;
        if (irq_v[0] !== 1'b0) $display("FAIL rise_irq_early got %b want 0", irq_v[0]);
        else pass++;
        tick(1);
        tot++;
        if (irq_v[0] !== 1'b1) $display("FAIL rise_irq got %b want 1", irq_v[0]);
        else pass++;
        exp_q.push_back(32'h01);
        rd(0, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL rise_cap got %h want %h", obs, e);
        else pass++;
        wr(0, ADDR_EDGECAP, 32'h1);
        tot++;
        if (irq_v[0] !== 1'b0) $display("FAIL rise_irq_clr got %b want 0", irq_v[0]);
        else pass++;
        exp_q.push_back(32'h0);
        rd(0, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL rise_cap_clr got %h want %h", obs, e);
        else pass++;
    endtask

    task automatic test_falling;
        logic [31:0] obs, e;
        in_f = 8'h0F;
        tick(LAT + 2);
        wr(1, ADDR_EDGECAP, 32'hFF);
        in_f = 8'h05;
        tick(LAT + 1);
        exp_q.push_back(32'h0A);
        rd(1, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL fall_cap got %h want %h", obs, e);
        else pass++;
        tot++;
        if (irq_v[1] !== 1'b0) $display("FAIL fall_irq_masked got %b want 0", irq_v[1]);
        else pass++;
        in_f = 8'h07;
        tick(LAT + 2);
        in_f = 8'h05;
        tick(LAT);
        wr(1, ADDR_EDGECAP, 32'h2);
        exp_q.push_back(32'h0A);
        rd(1, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL fall_set_wins got %h want %h", obs, e);
        else pass++;
        wr(1, ADDR_EDGECAP, 32'h8);
        exp_q.push_back(32'h02);
        rd(1, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL fall_w1c got %h want %h", obs, e);
        else pass++;
    endtask

    task automatic test_any;
        logic [31:0] obs, e;
        in_a = 8'h00;
        tick(LAT + 1);
        tot++;
        if (irq_v[2] !== 1'b0) $display("FAIL any_irq_nomask got %b want 0", irq_v[2]);
        else pass++;
        exp_q.push_back(32'hFF);
        rd(2, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL any_cap got %h want %h", obs, e);
        else pass++;
        wr(2, ADDR_IRQMASK, 32'h80);
        tot++;
        if (irq_v[2] !== 1'b1) $display("FAIL any_irq_mask got %b want 1", irq_v[2]);
        else pass++;
        exp_q.push_back(32'h80);
        rd(2, ADDR_IRQMASK, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL any_mask got %h want %h", obs, e);
        else pass++;
    endtask

    task automatic test_width1;
        rq_t rl[$];
        logic [31:0] obs, e;
        wr(3, ADDR_DATA, 32'hFFFF_FFFF);
        wr(3, ADDR_RSVD, 32'hFFFF_FFFF);
        rl.push_back('{3, ADDR_DATA,    32'h1, "w1_data0"});
        rl.push_back('{3, ADDR_RSVD,    32'h0, "w1_rsvd0"});
        rl.push_back('{3, ADDR_IRQMASK, 32'h0, "w1_mask0"});
        rl.push_back('{3, ADDR_EDGECAP, 32'h0, "w1_cap0"});
        for (int i = 0; i < rl.size(); i++) begin
            exp_q.push_back(rl[i].e);
            rd(rl[i].k, rl[i].a, obs);
            e = exp_q.pop_front();
            tot++;
            if (obs !== e) $display("FAIL %s got %h want %h", rl[i].n, obs, e);
            else pass++;
        end
        wr(3, ADDR_IRQMASK, 32'hFFFF_FFFF);
        in_1 = 1'b0;
        tick(LAT + 1);
        in_1 = 1'b1;
        tick(LAT + 1);
        tot++;
        if (irq_v[3] !== 1'b1) $display("FAIL w1_irq got %b want 1", irq_v[3]);
        else pass++;
        rl.delete();
        rl.push_back('{3, ADDR_DATA,    32'h1, "w1_data1"});
        rl.push_back('{3, ADDR_RSVD,    32'h0, "w1_rsvd1"});
        rl.push_back('{3, ADDR_IRQMASK, 32'h1, "w1_mask1"});
        rl.push_back('{3, ADDR_EDGECAP, 32'h1, "w1_cap1"});
        for (int i = 0; i < rl.size(); i++) begin
            exp_q.push_back(rl[i].e);
            rd(rl[i].k, rl[i].a, obs);
            e = exp_q.pop_front();
            tot++;
            if (obs !== e) $display("FAIL %s got %h want %h", rl[i].n, obs, e);
            else pass++;
        end
    endtask

    task automatic test_reset_mid;
        rq_t rl[$];
        logic [31:0] obs, e;
        wr(0, ADDR_IRQMASK, 32'hFF);
        in_r = 8'h00;
        tick(LAT + 1);
        in_r = 8'h33;
        tick(LAT + 1);
        exp_q.push_back(32'h33);
        rd(0, ADDR_EDGECAP, obs);
        e = exp_q.pop_front();
        tot++;
        if (obs !== e) $display("FAIL mid_cap got %h want %h", obs, e);
        else pass++;
        tot++;
        if (irq_v[0] !== 1'b1) $display("FAIL mid_irq got %b want 1", irq_v[0]);
        else pass++;
        #2;
        rst_n = 1'b0;
        #1;
        tot++;
        if (irq_v !== 4'h0) $display("FAIL mid_async_irq got %h want 0", irq_v);
        else pass++;
        tot++;
        if (rdv[0] !== 32'h0) $display("FAIL mid_async_rdata got %h want 0", rdv[0]);
        else pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        tot++;
        if (irq_v[0] !== 1'b0) $display("FAIL mid_irq_post got %b want 0", irq_v[0]);
        else pass++;
        rl.push_back('{0, ADDR_EDGECAP, 32'h0,  "mid_cap_post"});
        rl.push_back('{0, ADDR_IRQMASK, 32'h0,  "mid_mask_post"});
        rl.push_back('{0, ADDR_DATA,    32'h33, "mid_data_post"});
        for (int i = 0; i < rl.size(); i++) begin
            exp_q.push_back(rl[i].e);
            rd(rl[i].k, rl[i].a, obs);
            e = exp_q.pop_front();
            tot++;
            if (obs !== e) $display("FAIL %s got %h want %h", rl[i].n, obs, e);
            else pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        cs    = '0;
        wn    = 1'b1;
        wdata = '0;
        in_r  = 8'hFF;
        in_f  = 8'hFF;
        in_a  = 8'hFF;
        in_1  = 1'b1;
        test_reset();
        test_rising();
        test_falling();
        test_any();
        test_width1();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
